// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store over a valid/ready request and response pair,
// internal word RAM with byte-lane writes. Define DMEM_ERR_EN to enable misalignment/range errors.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Counter only needs to hold LATENCY-2; the response state is entered when it reaches zero.
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] idx;
  logic          acc_err;
  logic          accept;
  logic          is_write;

  assign idx      = req_addr[AW+1:2];
  assign is_write = (req_we != 4'b0000);
  assign accept   = (state == IDLE) && req_valid && !rst;

`ifdef DMEM_ERR_EN
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;
  assign acc_err = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= ADDR_LIMIT);
`else
  // Without error detection the low and high address bits simply fall away (wrapping access).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign acc_err = 1'b0;
`endif

  // Stores commit on the accept edge; erroring requests never touch the array.
  always_ff @(posedge clk) begin
    if (accept && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (req_we[i]) begin
          mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_err || is_write) ? 32'd0 : mem[idx];
            if (LATENCY == 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table, directed multi-cycle sequences, and a randomized run
// against a word-array reference model. Follows the DUT's DMEM_ERR_EN build option.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_we;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid_1, req_ready_1;
  logic [31:0] req_addr_1, req_wdata_1;
  logic [3:0]  req_we_1;
  logic        rsp_valid_1, rsp_ready_1, rsp_err_1;
  logic [31:0] rsp_rdata_1;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_1), .req_ready(req_ready_1), .req_addr(req_addr_1),
    .req_we(req_we_1), .req_wdata(req_wdata_1),
    .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1), .rsp_rdata(rsp_rdata_1), .rsp_err(rsp_err_1)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [DEPTH];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: error/index/lane rules computed directly from address arithmetic.
  function automatic bit model_err(input logic [31:0] a);
    return ERR_EN && (((a % 4) != 0) || (64'(a) >= 64'(4 * DEPTH)));
  endfunction

  task automatic model_apply(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                             output logic [31:0] exp_rd, output logic exp_er);
    int w;
    w = int'((a / 4) % DEPTH);
    exp_er = model_err(a);
    exp_rd = 32'd0;
    if (!exp_er) begin
      if (we != 4'b0000) begin
        for (int i = 0; i < 4; i++)
          if (we[i]) model[w][8*i +: 8] = wd[8*i +: 8];
      end else begin
        exp_rd = model[w];
      end
    end
  endtask

  // Called and returns at a negedge. keep=1 leaves req_valid asserted through the response.
  task automatic transact(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                          input int hold, input bit keep,
                          output logic [31:0] rd, output logic er);
    int n;
    req_addr = a; req_we = we; req_wdata = wd; req_valid = 1'b1; rsp_ready = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, LAT);
    rd = rsp_rdata;
    er = rsp_err;
    chk("busy_req_ready", {31'd0, req_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_err", {31'd0, rsp_err}, {31'd0, er});
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_hs_rdata", rsp_rdata, 32'd0);
  endtask

  task automatic reset_in_wait(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    req_addr = a; req_we = we; req_wdata = wd; req_valid = 1'b1;
    chk("rw_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rw_in_wait", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rw_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rw_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rw_rdata", rsp_rdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rw_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    $display("txn reset_in_wait addr=%h we=%b", a, we);
  endtask

  initial begin
    logic [31:0] rd, exp_rd, a, wd;
    logic        er, exp_er;
    logic [3:0]  we;
    int          w, kind;

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = '0; req_wdata = '0; rsp_ready = 1'b0;
    req_valid_1 = 1'b0; req_addr_1 = '0; req_we_1 = '0; req_wdata_1 = '0; rsp_ready_1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;

    vecs[0] = '{32'h10, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[1] = '{32'h10, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{32'h10, 4'b0101, 32'h11223344, 32'h0, 1'b0};
    vecs[3] = '{32'h10, 4'b0000, 32'h0, 32'hDE22BE44, 1'b0};
`ifdef DMEM_ERR_EN
    vecs[4] = '{32'h12, 4'b1111, 32'h55555555, 32'h0, 1'b1};
    vecs[5] = '{32'h10, 4'b0000, 32'h0, 32'hDE22BE44, 1'b0};
    vecs[6] = '{32'(4 * DEPTH), 4'b0000, 32'h0, 32'h0, 1'b1};
`else
    vecs[4] = '{32'h1000, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0};
    vecs[5] = '{32'h0, 4'b0000, 32'h0, 32'hCAFEF00D, 1'b0};
    vecs[6] = '{32'h12, 4'b0000, 32'h0, 32'hDE22BE44, 1'b0};
`endif

    for (int i = 0; i < 7; i++) begin
      transact(vecs[i].addr, vecs[i].we, vecs[i].wdata, 0, 1'b0, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      $display("txn vec%0d addr=%h we=%b rdata=%h err=%0b", i, vecs[i].addr, vecs[i].we, rd, er);
    end

    // Backpressure: response held 5 cycles while another request waits at the input.
    transact(32'h10, 4'b0000, 32'h0, 5, 1'b1, rd, er);
    chk("bp_rdata", rd, 32'hDE22BE44);
    $display("txn backpressure rdata=%h", rd);
    transact(32'h10, 4'b0000, 32'h0, 0, 1'b0, rd, er);
    chk("bp_next_rdata", rd, 32'hDE22BE44);
    $display("txn after_backpressure rdata=%h", rd);

    // Reset during WAIT: accepted write stays committed, no response appears.
    reset_in_wait(32'h20, 4'b1111, 32'h0BADCAFE);
    reset_in_wait(32'h20, 4'b0000, 32'h0);
    transact(32'h20, 4'b0000, 32'h0, 0, 1'b0, rd, er);
    chk("rw_committed", rd, 32'h0BADCAFE);
    $display("txn read_after_reset rdata=%h", rd);

    // LATENCY=1 instance: response valid right after the accept edge.
    for (int i = 0; i < 2; i++) begin
      req_addr_1 = 32'h8; req_we_1 = (i == 0) ? 4'b1111 : 4'b0000; req_wdata_1 = 32'h55AA1234;
      req_valid_1 = 1'b1;
      chk("l1_ready", {31'd0, req_ready_1}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid_1 = 1'b0;
      chk("l1_valid", {31'd0, rsp_valid_1}, 32'd1);
      chk("l1_rdata", rsp_rdata_1, (i == 0) ? 32'h0 : 32'h55AA1234);
      chk("l1_err", {31'd0, rsp_err_1}, 32'd0);
      rsp_ready_1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready_1 = 1'b0;
      chk("l1_post_valid", {31'd0, rsp_valid_1}, 32'd0);
      $display("txn lat1 op=%0d rdata=%h", i, rsp_rdata_1);
    end

    // Randomized run over a 32-word window, first filled with known data.
    for (int i = 0; i < 32; i++) begin
      wd = $urandom;
      model_apply(32'(i * 4), 4'b1111, wd, exp_rd, exp_er);
      transact(32'(i * 4), 4'b1111, wd, 0, 1'b0, rd, er);
    end
    for (int i = 0; i < 150; i++) begin
      w = $urandom_range(0, 31);
      kind = $urandom_range(0, 9);
      if (kind < 7)      a = 32'(w * 4);
      else if (kind < 9) a = 32'(w * 4 + $urandom_range(1, 3));
      else               a = 32'(w * 4 + 4 * DEPTH * $urandom_range(1, 3));
      we = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      wd = $urandom;
      model_apply(a, we, wd, exp_rd, exp_er);
      transact(a, we, wd, $urandom_range(0, 3), 1'b0, rd, er);
      chk("rand_rdata", rd, exp_rd);
      chk("rand_err", {31'd0, er}, {31'd0, exp_er});
      $display("txn rand%0d addr=%h we=%b rdata=%h err=%0b", i, a, we, rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
